// File: rtl/truth_table_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_pkg
// Brief    : Shared types, widths and bit-position helper for the truth-table
//            sweep controller and truth-table generators.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_pkg;

  localparam int TT_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_t;

  // Row index {in1,in2,in3} maps to table bit 7-idx (row 000 is the MSB).
  function automatic logic [IDX_W-1:0] tt_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(TT_W - 1) - idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweep_ctrl_if
// Brief    : Config/status and gate-side signals of the sweep controller.
//            slave = controller, master = config logic plus gate.
// Revision : 1.0 - initial release
// ============================================================================
interface truth_table_sweep_ctrl_if;
  import truth_table_pkg::*;

  logic            start;
  logic            abort;
  logic [TT_W-1:0] expected_tt;
  logic            dut_in1;
  logic            dut_in2;
  logic            dut_in3;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            result_valid;
  logic            pass;
  logic [TT_W-1:0] captured_tt;
  logic [TT_W-1:0] mismatch_mask;
  logic [TT_W-1:0] unstable_mask;

  modport slave (
    input  start, abort, expected_tt, dut_out,
    output dut_in1, dut_in2, dut_in3, busy, done, result_valid, pass,
           captured_tt, mismatch_mask, unstable_mask
  );

  modport master (
    output start, abort, expected_tt, dut_out,
    input  dut_in1, dut_in2, dut_in3, busy, done, result_valid, pass,
           captured_tt, mismatch_mask, unstable_mask
  );

endinterface
`default_nettype wire

// File: rtl/truth_table_sweep_ctrl_sweep_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : sweep_down_counter
// Brief    : Loadable down-counter with zero flag; times both the settle and
//            the sample window of each row.
// Revision : 1.0 - initial release
// ============================================================================
module sweep_down_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic      [CNT_W-1:0] count_o,
  output logic                  zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweep_ctrl
// Brief    : Steps a 3-input gate through rows 000..111, samples its output
//            after a settle window, rebuilds the truth table and compares it
//            with a snapshot of the expected table.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweep_ctrl
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 2,
  parameter int CNT_W         = 8
) (
  input wire logic                 clk,
  input wire logic                 rst,
  truth_table_sweep_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_DRIVE  = 3'(ST_DRIVE);
  localparam logic [2:0] S_SETTLE = 3'(ST_SETTLE);
  localparam logic [2:0] S_SAMPLE = 3'(ST_SAMPLE);
  localparam logic [2:0] S_DONE   = 3'(ST_DONE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_W - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] dut_in_q;
  logic [TT_W-1:0]  exp_q, cap_q, mm_q, un_q;
  logic             first_q, row_unst_q;
  logic             rv_q, pass_q;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             w_first, w_unst_now, w_row_mm;
  logic [IDX_W-1:0] w_pos;
  logic [TT_W-1:0]  w_mm_final;

  sweep_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  // Next-state, row index and window-counter control; abort overrides any busy state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_DRIVE;
          idx_d   = '0;
        end
      end
      S_DRIVE: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(SETTLE_CYCLES - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SAMPLES - 1);
          state_d  = S_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (cnt_zero) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DRIVE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
    end
  end

  // Per-sample evaluation: first sample is the reference, later ones flag instability.
  always_comb begin
    w_pos      = tt_pos(idx_q);
    w_first    = (cnt == CNT_W'(SAMPLES - 1));
    w_unst_now = w_first ? 1'b0 : (row_unst_q | (bus.dut_out != first_q));
    w_row_mm   = (bus.dut_out != exp_q[w_pos]) | w_unst_now;
    w_mm_final = mm_q;
    w_mm_final[w_pos] = w_row_mm;
  end

  // State, gate drive and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      dut_in_q   <= '0;
      exp_q      <= '0;
      cap_q      <= '0;
      mm_q       <= '0;
      un_q       <= '0;
      first_q    <= 1'b0;
      row_unst_q <= 1'b0;
      rv_q       <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d == S_IDLE) begin
        dut_in_q <= '0;
      end else if (state_d == S_DRIVE) begin
        dut_in_q <= idx_d;
      end
      if (state_q == S_IDLE) begin
        if (state_d == S_DRIVE) begin
          exp_q  <= bus.expected_tt;
          cap_q  <= '0;
          mm_q   <= '0;
          un_q   <= '0;
          rv_q   <= 1'b0;
          pass_q <= 1'b0;
        end
      end else if (bus.abort) begin
        rv_q   <= 1'b0;
        pass_q <= 1'b0;
      end else if (state_q == S_SAMPLE) begin
        if (w_first) begin
          first_q <= bus.dut_out;
        end
        row_unst_q <= w_unst_now;
        if (cnt_zero) begin
          cap_q[w_pos] <= bus.dut_out;
          un_q[w_pos]  <= w_unst_now;
          mm_q[w_pos]  <= w_row_mm;
          if (idx_q == LAST_IDX) begin
            rv_q   <= 1'b1;
            pass_q <= ~|w_mm_final;
          end
        end
      end
    end
  end

  assign bus.dut_in1       = dut_in_q[2];
  assign bus.dut_in2       = dut_in_q[1];
  assign bus.dut_in3       = dut_in_q[0];
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE) && !bus.abort;
  assign bus.result_valid  = rv_q;
  assign bus.pass          = pass_q;
  assign bus.captured_tt   = cap_q;
  assign bus.mismatch_mask = mm_q;
  assign bus.unstable_mask = un_q;

endmodule
`default_nettype wire
